// File: rtl/pc_gen_btb.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// Optional `PC_GEN_ALIGN_CHECK_EN adds a misaligned flag and forces aligned redirects and targets.
module pc_gen_btb #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BTB_ENTRIES  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            update_valid,
   input  logic [XLEN-1:0] update_pc,
   input  logic            update_taken,
   input  logic [XLEN-1:0] update_target,
`ifdef PC_GEN_ALIGN_CHECK_EN
   output logic            misaligned,
`endif
   output logic [XLEN-1:0] pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target
);

   localparam int IDX  = $clog2(BTB_ENTRIES);
   localparam int TAGW = XLEN - IDX - 2;

   logic            r_valid  [BTB_ENTRIES];
   logic [TAGW-1:0] r_tag    [BTB_ENTRIES];
   logic [XLEN-1:0] r_target [BTB_ENTRIES];
   logic [1:0]      r_ctr    [BTB_ENTRIES];
   logic [XLEN-1:0] r_pc;

   logic [IDX-1:0]  w_lookIdx;
   logic [TAGW-1:0] w_lookTag;
   logic            w_lookHit;
   logic [IDX-1:0]  w_updIdx;
   logic [TAGW-1:0] w_updTag;
   logic            w_updHit;
   logic [XLEN-1:0] w_redirectPc;
   logic            w_targetOk;
   logic [XLEN-1:0] w_nextPc;
   logic            w_unusedBits;

   assign w_lookIdx = r_pc[IDX+1:2];
   assign w_lookTag = r_pc[XLEN-1:IDX+2];
   assign w_lookHit = r_valid[w_lookIdx] && (r_tag[w_lookIdx] == w_lookTag);

   assign w_updIdx  = update_pc[IDX+1:2];
   assign w_updTag  = update_pc[XLEN-1:IDX+2];
   assign w_updHit  = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

   // Byte-offset bits never participate in indexing or tagging.
   assign w_unusedBits = ^{r_pc[1:0], update_pc[1:0]};

`ifdef PC_GEN_ALIGN_CHECK_EN
   logic r_misaligned;
   assign w_redirectPc = {redirect_pc[XLEN-1:2], 2'b00};
   assign w_targetOk   = (update_target[1:0] == 2'b00);
   assign misaligned   = r_misaligned;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_misaligned <= 1'b0;
      else       r_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
   end
`else
   assign w_redirectPc = redirect_pc;
   assign w_targetOk   = 1'b1;
`endif

   assign pc          = r_pc;
   assign pred_taken  = w_lookHit && r_ctr[w_lookIdx][1];
   assign pred_target = w_lookHit ? r_target[w_lookIdx] : '0;

   // Redirect beats stall, stall beats prediction, prediction beats fall-through.
   always_comb begin
      w_nextPc = r_pc + XLEN'(4);
      if (redirect_valid)  w_nextPc = w_redirectPc;
      else if (stall)      w_nextPc = r_pc;
      else if (pred_taken) w_nextPc = pred_target;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_pc <= RESET_VECTOR;
      else       r_pc <= w_nextPc;
   end

   // Training runs regardless of stall/redirect; lookups see the pre-update entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (update_valid) begin
         if (w_updHit) begin
            if (update_taken) begin
               if (r_ctr[w_updIdx] != 2'b11) r_ctr[w_updIdx] <= r_ctr[w_updIdx] + 2'b01;
               if (w_targetOk) r_target[w_updIdx] <= update_target;
            end else begin
               if (r_ctr[w_updIdx] != 2'b00) r_ctr[w_updIdx] <= r_ctr[w_updIdx] - 2'b01;
            end
         end else if (update_taken && w_targetOk) begin
            r_valid[w_updIdx]  <= 1'b1;
            r_tag[w_updIdx]    <= w_updTag;
            r_target[w_updIdx] <= update_target;
            r_ctr[w_updIdx]    <= 2'b10;
         end
      end
   end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed testbench for pc_gen_btb: fall-through, BTB training, saturation, stall/redirect, aliasing, wrap, reset.
module tb_pc_gen_btb;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;
`ifdef PC_GEN_ALIGN_CHECK_EN
   logic        misaligned;
`endif

   int vectors    = 0;
   int miscompares = 0;

   pc_gen_btb dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .update_valid(update_valid),
      .update_pc(update_pc),
      .update_taken(update_taken),
      .update_target(update_target),
`ifdef PC_GEN_ALIGN_CHECK_EN
      .misaligned(misaligned),
`endif
      .pc(pc),
      .pred_taken(pred_taken),
      .pred_target(pred_target)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, then land just after the edge that consumed them.
   task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc,
                                input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt);
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      update_valid   = uv;
      update_pc      = upc;
      update_taken   = ut;
      update_target  = utgt;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_pc", pc, 32'h0);
      checkOutput("reset_pred", {31'b0, pred_taken}, 32'h0);
      reset = 1'b0;

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("seq_pc4", pc, 32'h4);
      checkOutput("seq_pred4", {31'b0, pred_taken}, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("seq_pc8", pc, 32'h8);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("seq_pc12", pc, 32'hC);
      checkOutput("seq_pred12", {31'b0, pred_taken}, 32'h0);

      applyStimulus(0, 0, 0, 1, 32'h10, 1, 32'h80);
      checkOutput("alloc_pc", pc, 32'h10);
      checkOutput("alloc_pred", {31'b0, pred_taken}, 32'h1);
      checkOutput("alloc_tgt", pred_target, 32'h80);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("follow_pred", pc, 32'h80);

      applyStimulus(0, 0, 0, 1, 32'h10, 0, 0);
      applyStimulus(0, 0, 0, 1, 32'h10, 0, 0);
      checkOutput("nt_pc", pc, 32'h88);
      applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
      checkOutput("weak_pc", pc, 32'h10);
      checkOutput("weak_pred", {31'b0, pred_taken}, 32'h0);
      checkOutput("weak_tgt", pred_target, 32'h80);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("weak_fall", pc, 32'h14);

      // 00 -> 01 -> 10 -> 11 -> 11, then one decrement must leave it predicting taken.
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 32'h10, 1, 32'h80);
      checkOutput("sat_pc", pc, 32'h24);
      applyStimulus(0, 0, 0, 1, 32'h10, 0, 0);
      applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
      checkOutput("sat_pred", {31'b0, pred_taken}, 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("sat_follow", pc, 32'h80);

      applyStimulus(1, 1, 32'h200, 0, 0, 0, 0);
      checkOutput("stall_redir", pc, 32'h200);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 0);
         checkOutput("stall_hold", pc, 32'h200);
      end

      applyStimulus(0, 0, 0, 1, 32'h50, 1, 32'hC0);
      checkOutput("alias_pc", pc, 32'h204);
      applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
      checkOutput("alias_miss", {31'b0, pred_taken}, 32'h0);
      checkOutput("alias_tgt0", pred_target, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("alias_fall", pc, 32'h14);
      applyStimulus(0, 1, 32'h50, 0, 0, 0, 0);
      checkOutput("alias_hit", {31'b0, pred_taken}, 32'h1);
      checkOutput("alias_hit_tgt", pred_target, 32'hC0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("alias_follow", pc, 32'hC0);

      applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      checkOutput("wrap_top", pc, 32'hFFFF_FFFC);
      checkOutput("wrap_pred", {31'b0, pred_taken}, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("wrap_zero", pc, 32'h0);

      applyStimulus(0, 1, 32'h50, 0, 0, 0, 0);
      checkOutput("pre_rst_pred", {31'b0, pred_taken}, 32'h1);
      #2 reset = 1'b1;
      #1;
      checkOutput("midrst_pc", pc, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(0, 1, 32'h50, 0, 0, 0, 0);
      checkOutput("post_rst_pred", {31'b0, pred_taken}, 32'h0);
      checkOutput("post_rst_tgt", pred_target, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_fall", pc, 32'h54);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
